// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiter.
package axis_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first requester after last_grant, wrapping modulo N_SRC.
module rr_priority_pick #(
   parameter int N_SRC = 4,
   parameter int IW    = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic             valid,
   output logic [IW-1:0]    idx
);

   logic [IW-1:0] cand;

   // Scan farthest-first so the nearest requester is the final assignment.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N_SRC; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % N_SRC);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream sink.
module axis_rr_arbiter
   import axis_rr_arbiter_pkg::*;
#(
   parameter int N_SRC      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BEATS  = 16,
   localparam int IW        = clog2(N_SRC)
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [N_SRC-1:0]            s_axis_tvalid,
   input  logic [N_SRC-1:0]            s_axis_tlast,
   output logic [N_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready,
   output logic [IW-1:0]               grant_idx,
   output logic                        busy
);

   localparam int CW_RAW = clog2(MAX_BEATS + 1);
   localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam logic [CW-1:0] CNT_LAST =
      CW'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

   arb_state_e            state;
   logic [IW-1:0]         last_grant;
   logic [CW-1:0]         beat_cnt;
   logic [DATA_WIDTH-1:0] src_data [N_SRC];
   logic                  pick_valid;
   logic [IW-1:0]         pick_idx;
   logic                  beat;
   logic                  release_grant;

   for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
      assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_priority_pick #(
      .N_SRC (N_SRC),
      .IW    (IW)
   ) u_pick (
      .req        (s_axis_tvalid),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   // Outputs derive from state only, so reset kills tvalid asynchronously.
   assign busy          = (state == ST_GRANT);
   assign m_axis_tdata  = src_data[grant_idx];
   assign m_axis_tvalid = busy & s_axis_tvalid[grant_idx];
   assign m_axis_tlast  = busy & s_axis_tlast[grant_idx];

   always_comb begin
      s_axis_tready = '0;
      if (busy) s_axis_tready[grant_idx] = m_axis_tready;
   end

   assign beat          = m_axis_tvalid & m_axis_tready;
   assign release_grant = beat & (m_axis_tlast |
                          ((MAX_BEATS != 0) & (beat_cnt == CNT_LAST)));

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state      <= ST_IDLE;
         grant_idx  <= '0;
         last_grant <= IW'(N_SRC - 1);
         beat_cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_idx <= pick_idx;
                  beat_cnt  <= '0;
                  state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (release_grant) begin
                     last_grant <= grant_idx;
                     state      <= ST_IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule
